// File: rtl/agv_pkg.sv
// agv_pkg: direction, motor and sensor codes plus the motion state set shared with the path coordinator
package agv_pkg;
  localparam logic [1:0] DIR_STR = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_L = 2'b10;
  localparam logic [1:0] DIR_U = 2'b11;
  localparam logic [1:0] MOT_FWD = 2'b10;
  localparam logic [1:0] MOT_REV = 2'b01;
  localparam logic [1:0] MOT_OFF = 2'b00;
  localparam logic [2:0] LS_NONE = 3'b000;
  localparam logic [2:0] LS_NODE = 3'b111;
  localparam logic [2:0] LS_LFT = 3'b100;
  localparam logic [2:0] LS_LCT = 3'b110;
  localparam logic [2:0] LS_RGT = 3'b001;
  localparam logic [2:0] LS_RCT = 3'b011;
  typedef enum logic [2:0] {IDLE, FOLLOW, ADV, TURN_EXIT, TURN_SEEK, HALT, FAULT} state_t;
endpackage

// File: rtl/agv_pwm_gen.sv
// agv_pwm_gen: shared PWM period counter with a registered duty compare per motor
module agv_pwm_gen #(
  parameter int PERIOD = 1000,
  parameter int DW = $clog2(PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] duty_l_i,
  input  logic [DW-1:0] duty_r_i,
  input  logic          en_l_i,
  input  logic          en_r_i,
  output logic          pwm_l_o,
  output logic          pwm_r_o
);
  logic [DW-1:0] cnt_q;
  logic pwm_l_q, pwm_r_q;
  // free-running period counter; enables compare against the current duties
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      pwm_l_q <= 1'b0;
      pwm_r_q <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == DW'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
      pwm_l_q <= en_l_i && (cnt_q < duty_l_i);
      pwm_r_q <= en_r_i && (cnt_q < duty_r_i);
    end
  assign pwm_l_o = pwm_l_q;
  assign pwm_r_o = pwm_r_q;
endmodule

// File: rtl/agv_motion_ctrl.sv
// agv_motion_ctrl: line follower that executes node manoeuvres from the coordinator and drives the H-bridges
module agv_motion_ctrl #(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_FWD = 800,
  parameter int DUTY_CORR = 400,
  parameter int DUTY_TURN = 600,
  parameter int ADV_CYCLES = 10_000_000,
  parameter int TURN_MIN = 5_000_000,
  parameter int LOST_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       path_ready,
  input  logic [2:0] ip_from_ls,
  input  logic [1:0] dir_info,
  input  logic       stop,
  input  logic       obj_det,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       node_pulse,
  output logic       busy,
  output logic       fault
);
  import agv_pkg::*;
  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int LW = $clog2(LOST_CYCLES + 1);
  localparam int AW = $clog2(ADV_CYCLES + 1);
  localparam int TW = $clog2(TURN_MIN + 1);
  state_t state_q, state_d;
  logic [LW-1:0] lost_q, lost_d;
  logic [AW-1:0] adv_q, adv_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [1:0] edge_q, edge_d, dir_q, dir_d;
  logic [1:0] motor_l_q, motor_l_d, motor_r_q, motor_r_d;
  logic [DW-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
  logic armed_q, armed_d, ls1_q, node_q, node_d, busy_q, busy_d, fault_q, fault_d;
  logic frz, rise, trn;
  assign frz = obj_det && (state_q inside {FOLLOW, ADV, TURN_EXIT, TURN_SEEK});
  assign rise = ip_from_ls[1] && !ls1_q;
  // state, manoeuvre counters, node arming and centre-sensor history
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      lost_q <= '0;
      adv_q <= '0;
      turn_q <= '0;
      edge_q <= '0;
      dir_q <= DIR_STR;
      armed_q <= 1'b1;
      ls1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lost_q <= lost_d;
      adv_q <= adv_d;
      turn_q <= turn_d;
      edge_q <= edge_d;
      dir_q <= dir_d;
      armed_q <= armed_d;
      ls1_q <= ip_from_ls[1];
    end
  // next state; an obstacle freezes every counter and the state in motion states
  always_comb begin
    state_d = state_q;
    lost_d = lost_q;
    adv_d = adv_q;
    turn_d = turn_q;
    edge_d = edge_q;
    dir_d = dir_q;
    armed_d = (ip_from_ls != LS_NODE) ? 1'b1 : armed_q;
    if (!frz)
      case (state_q)
        IDLE: state_d = path_ready ? FOLLOW : IDLE;
        FOLLOW:
          if (lost_q == LW'(LOST_CYCLES)) state_d = FAULT;
          else begin
            lost_d = (ip_from_ls == LS_NONE) ? lost_q + 1'b1 : '0;
            if (ip_from_ls == LS_NODE && armed_q) begin
              state_d = ADV;
              armed_d = 1'b0;
            end
          end
        ADV:
          if (adv_q == AW'(ADV_CYCLES - 1)) begin
            adv_d = '0;
            dir_d = dir_info;
            state_d = stop ? HALT : (dir_info == DIR_STR) ? FOLLOW : TURN_EXIT;
          end else adv_d = adv_q + 1'b1;
        TURN_EXIT:
          if (turn_q == TW'(TURN_MIN - 1)) begin
            turn_d = '0;
            edge_d = '0;
            state_d = TURN_SEEK;
          end else turn_d = turn_q + 1'b1;
        TURN_SEEK: begin
          edge_d = edge_q + {1'b0, rise};
          if (edge_d == ((dir_q == DIR_U) ? 2'd2 : 2'd1)) begin
            edge_d = '0;
            lost_d = '0;
            state_d = FOLLOW;
          end
        end
        HALT: state_d = (!stop && path_ready) ? FOLLOW : HALT;
        default: state_d = state_q;
      endcase
  end
  // next outputs from the state being entered; 000 in FOLLOW keeps the last duties
  always_comb begin
    trn = state_d == TURN_EXIT || state_d == TURN_SEEK;
    motor_l_d = frz ? MOT_OFF : (state_d == FOLLOW || state_d == ADV) ? MOT_FWD :
                trn ? ((dir_d == DIR_R || dir_d == DIR_U) ? MOT_FWD : MOT_REV) : MOT_OFF;
    motor_r_d = frz ? MOT_OFF : (state_d == FOLLOW || state_d == ADV) ? MOT_FWD :
                trn ? ((dir_d == DIR_R || dir_d == DIR_U) ? MOT_REV : MOT_FWD) : MOT_OFF;
    duty_l_d = frz ? duty_l_q : state_d == ADV ? DW'(DUTY_FWD) : trn ? DW'(DUTY_TURN) :
               (state_d != FOLLOW || ip_from_ls == LS_NONE) ? duty_l_q :
               (ip_from_ls == LS_LCT || ip_from_ls == LS_LFT) ? DW'(DUTY_CORR) : DW'(DUTY_FWD);
    duty_r_d = frz ? duty_r_q : state_d == ADV ? DW'(DUTY_FWD) : trn ? DW'(DUTY_TURN) :
               (state_d != FOLLOW || ip_from_ls == LS_NONE) ? duty_r_q :
               (ip_from_ls == LS_RCT || ip_from_ls == LS_RGT) ? DW'(DUTY_CORR) : DW'(DUTY_FWD);
    node_d = !frz && state_q == FOLLOW && state_d == ADV;
    busy_d = !(state_d inside {IDLE, HALT, FAULT});
    fault_d = state_d == FAULT;
  end
  // registered drive outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      motor_l_q <= MOT_OFF;
      motor_r_q <= MOT_OFF;
      duty_l_q <= '0;
      duty_r_q <= '0;
      node_q <= 1'b0;
      busy_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      motor_l_q <= motor_l_d;
      motor_r_q <= motor_r_d;
      duty_l_q <= duty_l_d;
      duty_r_q <= duty_r_d;
      node_q <= node_d;
      busy_q <= busy_d;
      fault_q <= fault_d;
    end
  agv_pwm_gen #(.PERIOD(PWM_PERIOD), .DW(DW)) u_pwm (
    .clk(clk),
    .rst(rst),
    .duty_l_i(duty_l_q),
    .duty_r_i(duty_r_q),
    .en_l_i(motor_l_q != MOT_OFF),
    .en_r_i(motor_r_q != MOT_OFF),
    .pwm_l_o(pwm_l),
    .pwm_r_o(pwm_r)
  );
  assign motor_l = motor_l_q;
  assign motor_r = motor_r_q;
  assign node_pulse = node_q;
  assign busy = busy_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_agv_motion_ctrl.sv
// tb_agv_motion_ctrl: vector table with scoreboard for line following, plus manoeuvre sequences
module tb_agv_motion_ctrl;
  import agv_pkg::*;
  typedef struct {
    logic [2:0] ls;
    logic obj;
    logic [1:0] ml;
    logic [1:0] mr;
    int hl;
    int hr;
  } vec_t;
  logic clk = 1'b0;
  logic rst, path_ready, stop, obj_det, pwm_l, pwm_r, node_pulse, busy, fault;
  logic [2:0] ls;
  logic [1:0] dir_info, motor_l, motor_r;
  int checks = 0;
  int errors = 0;
  vec_t vt[9];
  vec_t sb[$];

  agv_motion_ctrl #(
    .PWM_PERIOD(10), .DUTY_FWD(8), .DUTY_CORR(4), .DUTY_TURN(6),
    .ADV_CYCLES(20), .TURN_MIN(8), .LOST_CYCLES(30)
  ) dut (
    .clk(clk), .rst(rst), .path_ready(path_ready), .ip_from_ls(ls), .dir_info(dir_info),
    .stop(stop), .obj_det(obj_det), .motor_l(motor_l), .motor_r(motor_r), .pwm_l(pwm_l),
    .pwm_r(pwm_r), .node_pulse(node_pulse), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_node(input string nm);
    int ok;
    ok = 0;
    for (int k = 0; k < 60 && ok == 0; k++) begin
      @(negedge clk);
      ok = int'(node_pulse);
    end
    chk({nm, "_node_seen"}, ok, 1);
  endtask

  // from the node-pulse cycle, wait for the turn drive; ADV must last exactly 20 cycles
  task automatic adv_to_turn(input string nm, input int tm);
    int k;
    k = 0;
    while ({motor_l, motor_r} == 4'b1010 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_adv_len"}, k, 20);
    chk({nm, "_drive"}, int'({motor_l, motor_r}), tm);
  endtask

  task automatic turn_seq(input logic [1:0] d, input int need, input string nm);
    int hl, hr, tm, done;
    tm = (d == DIR_L) ? 4'b0110 : 4'b1001;
    done = (need == 1) ? 13 : 17;
    ls = 3'b010;
    cyc(3);
    dir_info = d;
    ls = 3'b111;
    wait_node(nm);
    ls = 3'b000;
    adv_to_turn(nm, tm);
    hl = 0;
    hr = 0;
    for (int i = 0; i < 18; i++) begin
      ls = ((i == 4 || i == 5) || (i >= 12 && (need == 1 || i < 14 || i >= 16))) ? 3'b010 : 3'b000;
      @(negedge clk);
      if (i + 1 >= 2 && i + 1 <= 11) begin
        hl += int'(pwm_l);
        hr += int'(pwm_r);
      end
      if (i + 1 == 11) chk({nm, "_early_edge_ignored"}, int'({motor_l, motor_r}), tm);
      if (i + 1 == done - 1) chk({nm, "_still_turning"}, int'({motor_l, motor_r}), tm);
      if (i + 1 == done) chk({nm, "_reacquired"}, int'({motor_l, motor_r}), 4'b1010);
    end
    chk({nm, "_pwm_l_duty"}, hl, 6);
    chk({nm, "_pwm_r_duty"}, hr, 6);
    ls = 3'b010;
  endtask

  initial begin
    vec_t e;
    int hl, hr, n;
    vt[0] = '{3'b010, 1'b0, 2'b10, 2'b10, 8, 8};
    vt[1] = '{3'b110, 1'b0, 2'b10, 2'b10, 4, 8};
    vt[2] = '{3'b100, 1'b0, 2'b10, 2'b10, 4, 8};
    vt[3] = '{3'b101, 1'b0, 2'b10, 2'b10, 8, 8};
    vt[4] = '{3'b011, 1'b0, 2'b10, 2'b10, 8, 4};
    vt[5] = '{3'b001, 1'b0, 2'b10, 2'b10, 8, 4};
    vt[6] = '{3'b000, 1'b0, 2'b10, 2'b10, 8, 4};
    vt[7] = '{3'b110, 1'b1, 2'b00, 2'b00, 0, 0};
    vt[8] = '{3'b010, 1'b0, 2'b10, 2'b10, 8, 8};
    rst = 1'b1;
    path_ready = 1'b0;
    stop = 1'b0;
    obj_det = 1'b0;
    ls = 3'b010;
    dir_info = DIR_STR;
    cyc(3);
    rst = 1'b0;
    chk("rst_motors", int'({motor_l, motor_r}), 0);
    chk("rst_pwm", int'({pwm_l, pwm_r}), 0);
    chk("rst_flags", int'({node_pulse, busy, fault}), 0);
    cyc(3);
    chk("idle_wait_busy", int'(busy), 0);
    path_ready = 1'b1;
    cyc(2);
    chk("follow_busy", int'(busy), 1);
    chk("follow_motors", int'({motor_l, motor_r}), 4'b1010);
    foreach (vt[i]) begin
      ls = vt[i].ls;
      obj_det = vt[i].obj;
      sb.push_back(vt[i]);
      cyc(3);
      e = sb.pop_front();
      chk($sformatf("vec%0d_motor_l", i), int'(motor_l), int'(e.ml));
      chk($sformatf("vec%0d_motor_r", i), int'(motor_r), int'(e.mr));
      hl = 0;
      hr = 0;
      repeat (10) begin
        @(negedge clk);
        hl += int'(pwm_l);
        hr += int'(pwm_r);
      end
      chk($sformatf("vec%0d_pwm_l_duty", i), hl, e.hl);
      chk($sformatf("vec%0d_pwm_r_duty", i), hr, e.hr);
    end
    ls = 3'b111;
    n = 0;
    repeat (50) begin
      @(negedge clk);
      n += int'(node_pulse);
    end
    chk("node_single_pulse", n, 1);
    chk("node_back_follow", int'({motor_l, motor_r, busy}), 5'b10101);
    ls = 3'b010;
    cyc(3);
    ls = 3'b111;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      n += int'(node_pulse);
    end
    chk("node_second_pulse", n, 1);
    turn_seq(DIR_R, 1, "right");
    turn_seq(DIR_L, 1, "left");
    turn_seq(DIR_U, 2, "uturn");
    ls = 3'b010;
    dir_info = DIR_STR;
    cyc(3);
    ls = 3'b111;
    wait_node("obj");
    ls = 3'b010;
    cyc(5);
    obj_det = 1'b1;
    cyc(7);
    chk("obj_motors_off", int'({motor_l, motor_r}), 0);
    chk("obj_pwm_off", int'({pwm_l, pwm_r}), 0);
    cyc(8);
    obj_det = 1'b0;
    stop = 1'b1;
    cyc(14);
    chk("obj_adv_resumed", int'({motor_l, motor_r, busy}), 5'b10101);
    cyc(1);
    chk("halt_busy", int'(busy), 0);
    chk("halt_motors", int'({motor_l, motor_r}), 0);
    cyc(3);
    chk("halt_hold", int'(busy), 0);
    stop = 1'b0;
    cyc(2);
    chk("halt_exit_busy", int'(busy), 1);
    ls = 3'b010;
    cyc(3);
    dir_info = DIR_R;
    ls = 3'b111;
    wait_node("rst");
    ls = 3'b000;
    adv_to_turn("rst", 4'b1001);
    cyc(12);
    chk("seek_turning", int'({motor_l, motor_r}), 4'b1001);
    rst = 1'b1;
    #1;
    chk("rst_async_motors", int'({motor_l, motor_r}), 0);
    chk("rst_async_pwm_busy", int'({pwm_l, pwm_r, busy}), 0);
    path_ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    ls = 3'b010;
    cyc(4);
    chk("rst_idle_no_resume", int'({motor_l, motor_r, busy}), 0);
    path_ready = 1'b1;
    cyc(2);
    ls = 3'b000;
    cyc(25);
    chk("lost_no_fault_yet", int'(fault), 0);
    cyc(15);
    chk("lost_fault", int'(fault), 1);
    chk("fault_motors_busy", int'({motor_l, motor_r, busy}), 0);
    ls = 3'b010;
    cyc(10);
    chk("fault_sticky", int'({fault, motor_l, motor_r}), 5'b10000);
    rst = 1'b1;
    #1;
    chk("fault_cleared_by_rst", int'(fault), 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
